mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Initiator side of the byte-addressable X-Makina memory. Accepts one load/store request at a time from the
//  CPU control unit, drives one read port plus the byte-enabled write port, and returns a one-cycle response.
//  It handles byte-lane steering, alignment checks, read-latency wait and byte extraction.
//  Sits between the control unit / MDR path and the memory data port (read port 1).
// PARAMETERS
//  WORD          16  data width in bits; must equal the memory WORD
//  ADDR_W        16  byte-address width; memory word address is ADDR_W-1 bits
//  RD_LATENCY    1   cycles from the mem_rd strobe edge until mem_rd_data is valid (>=1)
//  BYTE_SIGN_EXT 0   1: byte loads sign-extend bit 7; 0: zero-extend
// PORTS
//  clk          in   1         system clock, all state on posedge
//  rst          in   1         synchronous, active-high reset
//  req_valid    in   1         request present
//  req_ready    out  1         controller idle, request accepted when valid&ready
//  req_wr       in   1         1=store, 0=load
//  req_byte     in   1         1=byte access, 0=word access
//  req_addr     in   ADDR_W    byte address
//  req_wdata    in   WORD      store data (byte store uses [7:0])
//  rsp_valid    out  1         one-cycle completion pulse
//  rsp_rdata    out  WORD      load result, valid with rsp_valid, held until next rsp
//  rsp_fault    out  1         misaligned word access, valid with rsp_valid
//  mem_rd       out  1         read strobe to memory read port
//  mem_wr       out  WORD/8    byte write enables, bit0 = low byte
//  mem_addr     out  ADDR_W-1  word address, drives both rd_addr and wr_addr
//  mem_wr_data  out  WORD      lane-steered store data
//  mem_rd_data  in   WORD      memory read data
// BEHAVIOUR
//  - All outputs are registered. Reset values: req_ready=1, rsp_valid=0, rsp_fault=0, rsp_rdata=0, mem_rd=0,
//    mem_wr=0, mem_addr=0, mem_wr_data=0. Reset takes the FSM to IDLE on the next edge from any state.
//  - FSM states: IDLE -> ACCESS -> [WAIT x RD_LATENCY, loads only] -> RESP -> IDLE.
//    A fault goes IDLE -> RESP directly.
//  - Accept (cycle 0): in IDLE, valid&ready. The request is latched and req_ready drops next cycle.
//    req_ready=1 only in IDLE; back-to-back requests are accepted no sooner than the cycle after RESP.
//  - Fault: word access with req_addr[0]=1. No memory strobe; rsp_valid=1 and rsp_fault=1 in cycle 1;
//    rsp_rdata is unchanged.
//  - Store (cycle 1 = ACCESS): mem_wr is held for exactly 1 cycle, with mem_addr=req_addr[ADDR_W-1:1].
//    Word store: mem_wr=2'b11, mem_wr_data=req_wdata.
//    Byte store: mem_wr_data={wdata[7:0],wdata[7:0]}; addr[0]=0 -> mem_wr=2'b01, addr[0]=1 -> 2'b10.
//    rsp_valid in cycle 2, rsp_fault=0.
//  - Load: mem_rd=1 for exactly the ACCESS cycle (cycle 1). A down-counter then runs for RD_LATENCY WAIT cycles.
//    mem_rd_data is captured at the end of the last WAIT cycle; rsp_valid is asserted in cycle 2+RD_LATENCY
//    (cycle 3 at default).
//    Word load: rsp_rdata=mem_rd_data.
//    Byte load: the selected byte is [7:0] for addr[0]=0, [15:8] for addr[0]=1; it is placed in [7:0] and the
//    upper byte is extended per BYTE_SIGN_EXT.
//  - mem_addr holds its value from ACCESS through RESP and keeps its last value while IDLE.
//    mem_rd and mem_wr are never both 1.
//  - rsp_valid is a single-cycle pulse with no backpressure; the consumer must sample it.
//  - rst during ACCESS: the strobe already registered for that cycle is still seen by memory and the write
//    commits. All strobes are 0 from the next cycle; no rsp_valid is issued for the aborted request.
//  - req_valid with req_ready=0 is ignored, not queued. Request fields are don't-care when not accepted.
//  - Address wrap: the address is used as-is, with no carry. 0xFFFF is a valid byte address (word 0x7FFF, upper lane).
// STRUCTURE
//  - Package xm_mem_pkg: BYTE=8 localparam, typedef enum {IDLE,ACCESS,WAIT,RESP} mac_state_t,
//    typedef enum {ACC_WORD,ACC_BYTE} acc_size_t.
//  - Sub-module xm_byte_lane: combinational store lane steering (data + enables) and load byte
//    extraction/extension; instanced once.
//  - Top holds the FSM, latency counter ($clog2(RD_LATENCY+1) bits), request latch and output registers.
// TESTING (bench pairs with the memory model, ACTIVE_EDGE=1, READ_PORTS=2, port 1 used)
//  - Reset: assert rst 2 cycles mid-load -> all strobes 0, req_ready=1, no rsp_valid, FSM in IDLE.
//  - Word store 0xBEEF @0x0010, then word load @0x0010 -> mem_wr=11 for 1 cycle at word 0x0008;
//    rsp at cycle 2 / 3, rsp_rdata=0xBEEF.
//  - Byte store 0x5A @0x0011 over 0xBEEF, then word load -> mem_wr=10, rsp_rdata=0x5AEF.
//  - Byte load @0x0011 of 0x80EF: SIGN_EXT=0 -> 0x0080; SIGN_EXT=1 -> 0xFF80.
//  - Word load @0x0013 -> rsp_fault=1 at cycle 1, mem_rd/mem_wr never asserted, rsp_rdata unchanged.
//  - RD_LATENCY=3, req_valid held high continuously -> rsp at cycle 5, next accept only after RESP,
//    no dropped or duplicated response.

Source files
------------

// File: rtl/xm_mem_pkg.sv
// Shared types for the X-Makina memory initiator: access FSM states and access sizes.
package xm_mem_pkg;

  localparam int unsigned BYTE = 8;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} mac_state_t;

  typedef enum logic {ACC_WORD, ACC_BYTE} acc_size_t;

endpackage

// File: rtl/xm_byte_lane.sv
// Byte-lane steering for stores (replicated data + lane enables) and byte extraction for loads.
module xm_byte_lane
  import xm_mem_pkg::*;
#(
  parameter int unsigned WORD          = 16,
  parameter bit          BYTE_SIGN_EXT = 1'b0
) (
  input  acc_size_t              st_size,
  input  logic                   st_lane,
  input  logic [WORD-1:0]        st_wdata,
  output logic [WORD/BYTE-1:0]   st_wen,
  output logic [WORD-1:0]        st_data,
  input  acc_size_t              ld_size,
  input  logic                   ld_lane,
  input  logic [WORD-1:0]        ld_rdata,
  output logic [WORD-1:0]        ld_data
);

  localparam int unsigned Lanes = WORD / BYTE;

  logic [BYTE-1:0] ld_byte;
  logic            ld_ext;

  always_comb begin
    st_wen  = '1;
    st_data = st_wdata;
    if (st_size == ACC_BYTE) begin
      // Byte stores drive the byte on every lane; the enable picks the one that lands.
      st_data          = {Lanes{st_wdata[BYTE-1:0]}};
      st_wen           = '0;
      st_wen[st_lane]  = 1'b1;
    end
  end

  always_comb begin
    ld_byte = ld_lane ? ld_rdata[2*BYTE-1:BYTE] : ld_rdata[BYTE-1:0];
    ld_ext  = BYTE_SIGN_EXT & ld_byte[BYTE-1];
    ld_data = (ld_size == ACC_BYTE) ? {{(WORD-BYTE){ld_ext}}, ld_byte} : ld_rdata;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store initiator for the byte-addressable X-Makina memory.
module mem_access_ctrl
  import xm_mem_pkg::*;
#(
  parameter int unsigned WORD          = 16,
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned RD_LATENCY    = 1,
  parameter bit          BYTE_SIGN_EXT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic                 req_byte,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [WORD-1:0]      req_wdata,
  output logic                 rsp_valid,
  output logic [WORD-1:0]      rsp_rdata,
  output logic                 rsp_fault,
  output logic                 mem_rd,
  output logic [WORD/BYTE-1:0] mem_wr,
  output logic [ADDR_W-2:0]    mem_addr,
  output logic [WORD-1:0]      mem_wr_data,
  input  logic [WORD-1:0]      mem_rd_data
);

  localparam int unsigned CntW = $clog2(RD_LATENCY + 1);

  mac_state_t          state_q;
  logic [CntW-1:0]     cnt_q;
  acc_size_t           size_q;
  logic                lane_q;
  logic                wr_q;

  acc_size_t           req_size;
  logic                req_fault;
  logic [WORD/BYTE-1:0] st_wen;
  logic [WORD-1:0]     st_data;
  logic [WORD-1:0]     ld_data;

  assign req_size  = req_byte ? ACC_BYTE : ACC_WORD;
  assign req_fault = (req_size == ACC_WORD) && req_addr[0];

  xm_byte_lane #(
    .WORD          (WORD),
    .BYTE_SIGN_EXT (BYTE_SIGN_EXT)
  ) u_byte_lane (
    .st_size  (req_size),
    .st_lane  (req_addr[0]),
    .st_wdata (req_wdata),
    .st_wen   (st_wen),
    .st_data  (st_data),
    .ld_size  (size_q),
    .ld_lane  (lane_q),
    .ld_rdata (mem_rd_data),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      size_q      <= ACC_WORD;
      lane_q      <= 1'b0;
      wr_q        <= 1'b0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_fault   <= 1'b0;
      rsp_rdata   <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= '0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            size_q    <= req_size;
            lane_q    <= req_addr[0];
            wr_q      <= req_wr;
            if (req_fault) begin
              // Misaligned word: answer immediately, memory is never touched.
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b1;
              state_q   <= RESP;
            end else begin
              mem_addr <= req_addr[ADDR_W-1:1];
              if (req_wr) begin
                mem_wr      <= st_wen;
                mem_wr_data <= st_data;
              end else begin
                mem_rd <= 1'b1;
              end
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          mem_rd <= 1'b0;
          mem_wr <= '0;
          if (wr_q) begin
            rsp_valid <= 1'b1;
            state_q   <= RESP;
          end else begin
            cnt_q   <= CntW'(RD_LATENCY);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == CntW'(1)) begin
            rsp_rdata <= ld_data;
            rsp_valid <= 1'b1;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_fault <= 1'b0;
          req_ready <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (latency 1 zero-extend, latency 3 sign-extend),
// each against its own latency-accurate memory, checked every cycle by a transaction-level model.
module tb_mem_access_ctrl;

  localparam int NI = 2;
  localparam int KFAULT = 0;
  localparam int KSTORE = 1;
  localparam int KLOAD  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid [NI];
  logic        req_wr, req_byte;
  logic [15:0] req_addr, req_wdata;
  logic        req_ready [NI];
  logic        rsp_valid [NI];
  logic        rsp_fault [NI];
  logic        mem_rd    [NI];
  logic [1:0]  mem_wr    [NI];
  logic [14:0] mem_addr  [NI];
  logic [15:0] rsp_rdata [NI];
  logic [15:0] mem_wr_data [NI];
  logic [15:0] mem_rd_data [NI];

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic bit se_of(int i);
    return (i == 0) ? 1'b0 : 1'b1;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned L  = (g == 0) ? 1 : 3;
    localparam bit          SE = (g == 0) ? 1'b0 : 1'b1;

    logic [15:0] mem  [32768] = '{default: 16'h0};
    logic [15:0] pipe [L];
    logic        pv   [L];

    mem_access_ctrl #(
      .WORD          (16),
      .ADDR_W        (16),
      .RD_LATENCY    (L),
      .BYTE_SIGN_EXT (SE)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid[g]),
      .req_ready   (req_ready[g]),
      .req_wr      (req_wr),
      .req_byte    (req_byte),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid[g]),
      .rsp_rdata   (rsp_rdata[g]),
      .rsp_fault   (rsp_fault[g]),
      .mem_rd      (mem_rd[g]),
      .mem_wr      (mem_wr[g]),
      .mem_addr    (mem_addr[g]),
      .mem_wr_data (mem_wr_data[g]),
      .mem_rd_data (mem_rd_data[g])
    );

    // Memory: byte-enabled write on the strobe edge; read data valid only L edges after strobe.
    always @(posedge clk) begin
      if (mem_wr[g][0]) mem[mem_addr[g]][7:0]  <= mem_wr_data[g][7:0];
      if (mem_wr[g][1]) mem[mem_addr[g]][15:8] <= mem_wr_data[g][15:8];
      pv[0]   <= mem_rd[g];
      pipe[0] <= mem[mem_addr[g]];
      for (int s = 1; s < L; s++) begin
        pv[s]   <= pv[s-1];
        pipe[s] <= pipe[s-1];
      end
    end
    assign mem_rd_data[g] = pv[L-1] ? pipe[L-1] : 16'h0BAD;
  end

  // Transaction-level reference model state.
  logic [15:0] ref_mem [NI][32768] = '{default: '{default: 16'h0}};
  bit          m_busy   [NI];
  int          m_k      [NI];
  int          m_kind   [NI];
  int          m_resp_k [NI];
  logic [1:0]  m_wen    [NI];
  logic [15:0] m_wdata  [NI];
  logic [15:0] m_result [NI];
  logic [15:0] e_rdata  [NI];
  logic [14:0] e_addr   [NI];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] load_value(int i, logic [15:0] addr, bit is_byte);
    logic [15:0] w;
    int          b;
    w = ref_mem[i][addr[15:1]];
    if (!is_byte) return w;
    b = (int'(w) >> (addr[0] ? 8 : 0)) & 255;
    if (se_of(i) && b >= 128) b = b + 16'hFF00;
    return 16'(b);
  endfunction

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_busy[i]  = 1'b0;
        m_k[i]     = 0;
        e_rdata[i] = 16'h0;
        e_addr[i]  = 15'h0;
      end else if (m_busy[i]) begin
        m_k[i]++;
        if (m_k[i] == m_resp_k[i] && m_kind[i] == KLOAD) e_rdata[i] = m_result[i];
        if (m_k[i] > m_resp_k[i]) begin
          m_busy[i] = 1'b0;
          m_k[i]    = 0;
        end
      end else if (req_valid[i]) begin
        m_busy[i] = 1'b1;
        m_k[i]    = 1;
        if (!req_byte && req_addr[0]) begin
          m_kind[i]   = KFAULT;
          m_resp_k[i] = 1;
        end else begin
          e_addr[i] = req_addr[15:1];
          if (req_wr) begin
            m_kind[i]   = KSTORE;
            m_resp_k[i] = 2;
            m_wen[i]    = !req_byte ? 2'b11 : (req_addr[0] ? 2'b10 : 2'b01);
            m_wdata[i]  = req_byte ? {req_wdata[7:0], req_wdata[7:0]} : req_wdata;
            if (m_wen[i][0]) ref_mem[i][req_addr[15:1]][7:0]  = m_wdata[i][7:0];
            if (m_wen[i][1]) ref_mem[i][req_addr[15:1]][15:8] = m_wdata[i][15:8];
          end else begin
            m_kind[i]   = KLOAD;
            m_resp_k[i] = 2 + lat_of(i);
            m_result[i] = load_value(i, req_addr, req_byte);
          end
        end
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < NI; i++) begin
      bit   ev, est;
      ev  = m_busy[i] && (m_k[i] == m_resp_k[i]);
      est = m_busy[i] && m_kind[i] == KSTORE && m_k[i] == 1;
      chk($sformatf("req_ready[%0d]", i), 32'(req_ready[i]), 32'(!m_busy[i]));
      chk($sformatf("rsp_valid[%0d]", i), 32'(rsp_valid[i]), 32'(ev));
      chk($sformatf("rsp_fault[%0d]", i), 32'(rsp_fault[i]), 32'(ev && m_kind[i] == KFAULT));
      chk($sformatf("mem_rd[%0d]", i), 32'(mem_rd[i]),
          32'(m_busy[i] && m_kind[i] == KLOAD && m_k[i] == 1));
      chk($sformatf("mem_wr[%0d]", i), 32'(mem_wr[i]), 32'(est ? m_wen[i] : 2'b00));
      if (est) chk($sformatf("mem_wr_data[%0d]", i), 32'(mem_wr_data[i]), 32'(m_wdata[i]));
      if (!(m_busy[i] && m_kind[i] == KFAULT))
        chk($sformatf("mem_addr[%0d]", i), 32'(mem_addr[i]), 32'(e_addr[i]));
      chk($sformatf("rsp_rdata[%0d]", i), 32'(rsp_rdata[i]), 32'(e_rdata[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  // Issue one request from idle; report response latency (cycles after accept) and cycle-1 strobes.
  task automatic do_req(input int i, input bit wr, input bit byt, input logic [15:0] addr,
                        input logic [15:0] wdata, output logic [15:0] rdata, output bit fault,
                        output int lat, output logic [1:0] wr_seen, output logic [14:0] addr_seen,
                        output bit strobe);
    bit got;
    req_wr = wr; req_byte = byt; req_addr = addr; req_wdata = wdata;
    req_valid[i] = 1'b1;
    tick();
    req_valid[i] = 1'b0;
    got = 0; lat = 0; rdata = 16'h0; fault = 0; strobe = 0;
    wr_seen = mem_wr[i]; addr_seen = mem_addr[i];
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) tick();
      strobe = strobe | mem_rd[i] | (|mem_wr[i]);
      if (rsp_valid[i]) begin
        got = 1; lat = c; rdata = rsp_rdata[i]; fault = rsp_fault[i];
        break;
      end
    end
    chk($sformatf("rsp_timeout[%0d]", i), 32'(got), 32'd1);
    tick();
  endtask

  initial begin
    logic [15:0] rd;
    logic [1:0]  ws;
    logic [14:0] as;
    bit          flt, stb;
    int          lat, pulses, first;
    logic [15:0] prev;

    for (int i = 0; i < NI; i++) req_valid[i] = 1'b0;
    req_wr = 0; req_byte = 0; req_addr = 16'h0; req_wdata = 16'h0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_ready[%0d]", i), 32'(req_ready[i]), 32'd1);
      chk($sformatf("rst_rsp_valid[%0d]", i), 32'(rsp_valid[i]), 32'd0);
      chk($sformatf("rst_strobes[%0d]", i), 32'({mem_rd[i], mem_wr[i]}), 32'd0);
      chk($sformatf("rst_addr[%0d]", i), 32'(mem_addr[i]), 32'd0);
      chk($sformatf("rst_wdata[%0d]", i), 32'(mem_wr_data[i]), 32'd0);
      chk($sformatf("rst_rdata[%0d]", i), 32'(rsp_rdata[i]), 32'd0);
    end

    for (int i = 0; i < NI; i++) begin
      // Word store then word load.
      do_req(i, 1, 0, 16'h0010, 16'hBEEF, rd, flt, lat, ws, as, stb);
      chk($sformatf("st_word_wen[%0d]", i), 32'(ws), 32'h3);
      chk($sformatf("st_word_addr[%0d]", i), 32'(as), 32'h0008);
      chk($sformatf("st_word_lat[%0d]", i), 32'(lat), 32'd2);
      chk($sformatf("st_word_fault[%0d]", i), 32'(flt), 32'd0);
      do_req(i, 0, 0, 16'h0010, 16'h0, rd, flt, lat, ws, as, stb);
      chk($sformatf("ld_word_data[%0d]", i), 32'(rd), 32'hBEEF);
      chk($sformatf("ld_word_lat[%0d]", i), 32'(lat), 32'(2 + lat_of(i)));
      // Byte store to the upper lane.
      do_req(i, 1, 1, 16'h0011, 16'h125A, rd, flt, lat, ws, as, stb);
      chk($sformatf("st_byte_wen[%0d]", i), 32'(ws), 32'h2);
      do_req(i, 0, 0, 16'h0010, 16'h0, rd, flt, lat, ws, as, stb);
      chk($sformatf("ld_merge[%0d]", i), 32'(rd), 32'h5AEF);
      // Byte loads with and without sign bit.
      do_req(i, 1, 1, 16'h0011, 16'h0080, rd, flt, lat, ws, as, stb);
      do_req(i, 0, 1, 16'h0011, 16'h0, rd, flt, lat, ws, as, stb);
      chk($sformatf("ld_byte_hi[%0d]", i), 32'(rd), se_of(i) ? 32'hFF80 : 32'h0080);
      do_req(i, 0, 1, 16'h0010, 16'h0, rd, flt, lat, ws, as, stb);
      chk($sformatf("ld_byte_lo[%0d]", i), 32'(rd), se_of(i) ? 32'hFFEF : 32'h00EF);
      // Top of the address space.
      do_req(i, 1, 1, 16'hFFFF, 16'h003C, rd, flt, lat, ws, as, stb);
      chk($sformatf("st_ffff_wen[%0d]", i), 32'(ws), 32'h2);
      chk($sformatf("st_ffff_addr[%0d]", i), 32'(as), 32'h7FFF);
      do_req(i, 0, 1, 16'hFFFF, 16'h0, rd, flt, lat, ws, as, stb);
      chk($sformatf("ld_ffff[%0d]", i), 32'(rd), 32'h003C);
      // Misaligned word load faults without touching memory.
      prev = rsp_rdata[i];
      do_req(i, 0, 0, 16'h0013, 16'h0, rd, flt, lat, ws, as, stb);
      chk($sformatf("fault_flag[%0d]", i), 32'(flt), 32'd1);
      chk($sformatf("fault_lat[%0d]", i), 32'(lat), 32'd1);
      chk($sformatf("fault_strobe[%0d]", i), 32'(stb), 32'd0);
      chk($sformatf("fault_rdata[%0d]", i), 32'(rd), 32'(prev));

      // Reset in the middle of a load.
      req_wr = 0; req_byte = 0; req_addr = 16'h0010;
      req_valid[i] = 1'b1; tick();
      req_valid[i] = 1'b0; tick();
      rst = 1'b1; pulses = 0;
      tick(); pulses += int'(rsp_valid[i]);
      tick(); pulses += int'(rsp_valid[i]);
      rst = 1'b0;
      tick(); pulses += int'(rsp_valid[i]);
      chk($sformatf("rst_ld_pulses[%0d]", i), 32'(pulses), 32'd0);
      chk($sformatf("rst_ld_ready[%0d]", i), 32'(req_ready[i]), 32'd1);
      chk($sformatf("rst_ld_strobes[%0d]", i), 32'({mem_rd[i], mem_wr[i]}), 32'd0);

      // Reset during a store's access cycle: the write still lands, no response.
      req_wr = 1; req_byte = 0; req_addr = 16'h0020; req_wdata = 16'h1234;
      req_valid[i] = 1'b1; tick();
      req_valid[i] = 1'b0; rst = 1'b1; pulses = 0;
      tick(); pulses += int'(rsp_valid[i]);
      rst = 1'b0;
      tick(); pulses += int'(rsp_valid[i]);
      tick(); pulses += int'(rsp_valid[i]);
      chk($sformatf("rst_st_pulses[%0d]", i), 32'(pulses), 32'd0);
      do_req(i, 0, 0, 16'h0020, 16'h0, rd, flt, lat, ws, as, stb);
      chk($sformatf("rst_st_commit[%0d]", i), 32'(rd), 32'h1234);

      // req_valid held high: one response per accepted request, no overlap.
      req_wr = 0; req_byte = 0; req_addr = 16'h0020;
      req_valid[i] = 1'b1; pulses = 0; first = 0;
      for (int c = 1; c <= 24; c++) begin
        tick();
        if (rsp_valid[i]) begin
          pulses++;
          if (first == 0) first = c;
          chk($sformatf("held_data[%0d]", i), 32'(rsp_rdata[i]), 32'h1234);
        end
      end
      req_valid[i] = 1'b0;
      tick(); tick();
      chk($sformatf("held_first[%0d]", i), 32'(first), 32'(2 + lat_of(i)));
      chk($sformatf("held_pulses[%0d]", i), 32'(pulses), 32'(24 / (3 + lat_of(i))));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
